// File: rtl/operand_shift_register_pkg.sv
// Shared widths, constants and the sweep state type for the operand shift stage.
package operand_shift_register_pkg;
  localparam int DW    = 16;
  localparam int DW_2  = 2 * DW;
  localparam int CNT_W = $clog2(DW);

  localparam logic [DW-1:0] ONE      = DW'(1);
  localparam logic [DW-1:0] ZERO     = '0;
  localparam logic          BIT_ZERO = 1'b0;
  localparam logic          BIT_ONE  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shift_state_e;
endpackage

// File: rtl/operand_shift_register_if.sv
// Operand/control bundle between the control unit and the operand shift stage.
interface operand_shift_register_if #(
  parameter int DW = operand_shift_register_pkg::DW
);
  logic                                   start;
  logic                                   enable;
  logic [DW-1:0]                          multiplier;
  logic [DW-1:0]                          multiplicand;
  logic [DW-1:0]                          rgstr1;
  logic [2*DW-1:0]                        rgstr2;
  logic                                   sign_out;
  logic                                   zero_op;
  logic                                   busy;
  logic                                   shift_done;
  operand_shift_register_pkg::shift_state_e state;

  // Handshake: start is a one-cycle load strobe and always wins; enable is a
  // step qualifier honoured only while sweeping. Outputs are registered and
  // valid the cycle after the input that caused them; no backpressure exists.
  modport master (
    output start, enable, multiplier, multiplicand,
    input  rgstr1, rgstr2, sign_out, zero_op, busy, shift_done, state
  );

  modport slave (
    input  start, enable, multiplier, multiplicand,
    output rgstr1, rgstr2, sign_out, zero_op, busy, shift_done, state
  );
endinterface

// File: rtl/operand_shift_register_twos_magnitude.sv
// Combinational two's-complement magnitude; the most negative value maps to 2^(W-1).
module twos_magnitude #(
  parameter int W = 16
) (
  input  logic [W-1:0] value,
  output logic [W-1:0] magnitude
);
  assign magnitude = value[W-1] ? (~value + W'(1)) : value;
endmodule

// File: rtl/operand_shift_register.sv
// Captures signed operands as magnitudes and walks the multiplicand left once per sweep step.
module operand_shift_register #(
  parameter int DW = operand_shift_register_pkg::DW
) (
  input  logic                      clk,
  input  logic                      rst,
  operand_shift_register_if.slave   bus
);
  import operand_shift_register_pkg::*;

  localparam int DW_2  = 2 * DW;
  localparam int CNT_W = $clog2(DW);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DW - 1);

  logic [DW-1:0]   mag_a;
  logic [DW-1:0]   mag_b;
  shift_state_e    state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DW-1:0]   r1_q;
  logic [DW_2-1:0] r2_q;
  logic            sign_q;
  logic            zero_q;
  logic            busy_q;
  logic            done_q;

  twos_magnitude #(.W(DW)) u_mag_a (.value(bus.multiplier),   .magnitude(mag_a));
  twos_magnitude #(.W(DW)) u_mag_b (.value(bus.multiplicand), .magnitude(mag_b));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      sign_q  <= BIT_ZERO;
      zero_q  <= BIT_ZERO;
      busy_q  <= BIT_ZERO;
      done_q  <= BIT_ZERO;
    end else if (bus.start) begin
      // A load restarts from any state, so a sweep in progress is abandoned.
      state_q <= SHIFT;
      cnt_q   <= '0;
      r1_q    <= mag_a;
      r2_q    <= {{DW{1'b0}}, mag_b};
      sign_q  <= bus.multiplier[DW-1] ^ bus.multiplicand[DW-1];
      zero_q  <= (bus.multiplier == '0) || (bus.multiplicand == '0);
      busy_q  <= BIT_ONE;
      done_q  <= BIT_ZERO;
    end else begin
      case (state_q)
        SHIFT: begin
          if (bus.enable) begin
            // The final step only retires the sweep; the shift is already at DW-1.
            if (cnt_q == LAST_STEP) begin
              state_q <= DONE;
              busy_q  <= BIT_ZERO;
              done_q  <= BIT_ONE;
            end else begin
              r2_q  <= r2_q << 1;
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.rgstr1     = r1_q;
  assign bus.rgstr2     = r2_q;
  assign bus.sign_out   = sign_q;
  assign bus.zero_op    = zero_q;
  assign bus.busy       = busy_q;
  assign bus.shift_done = done_q;
  assign bus.state      = state_q;
endmodule
